// File: rtl/if_chan_router_pkg.sv
// if_chan_router_pkg: shared constants and the FSM state type for the host-interface router.
//   DIR_IN / DIR_OUT  burst direction encoding on cmd_dir
//   CH_*              channel indices within each direction
//   state_t           router FSM states
package if_chan_router_pkg;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    localparam logic [3:0] CH_IN_CFG     = 4'd0;
    localparam logic [3:0] CH_IN_FLGWEI  = 4'd1;
    localparam logic [3:0] CH_IN_WEI     = 4'd2;
    localparam logic [3:0] CH_IN_ACT     = 4'd3;
    localparam logic [3:0] CH_OUT_FLGOFM = 4'd0;
    localparam logic [3:0] CH_OUT_OFM    = 4'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_IN, ST_OUT, ST_DRAIN} state_t;

endpackage

// File: rtl/if_chan_router_if.sv
// if_chan_router_if: bundle of the router's command, stream and GBF signals.
//   slave  : router side (takes commands and streams, drives GBF ports and status)
//   master : host/environment side
interface if_chan_router_if #(
    parameter int DW         = 16,
    parameter int AW         = 10,
    parameter int NUM_IN_CH  = 4,
    parameter int NUM_OUT_CH = 2,
    parameter int LEN_W      = 12
);
    logic                       cmd_val;
    logic                       cmd_rdy;
    logic                       cmd_dir;
    logic [3:0]                 cmd_ch;
    logic [LEN_W-1:0]           cmd_len;
    logic                       in_val;
    logic [DW-1:0]              in_dat;
    logic                       in_rdy;
    logic                       out_val;
    logic [DW-1:0]              out_dat;
    logic                       out_rdy;
    logic [NUM_IN_CH-1:0]       gbf_wr_en;
    logic [NUM_IN_CH*AW-1:0]    gbf_wr_addr;
    logic [DW-1:0]              gbf_wr_dat;
    logic [NUM_OUT_CH-1:0]      gbf_rd_en;
    logic [NUM_OUT_CH*AW-1:0]   gbf_rd_addr;
    logic [NUM_OUT_CH*DW-1:0]   gbf_rd_dat;
    logic [NUM_OUT_CH-1:0]      gbf_rd_avail;
    logic [NUM_IN_CH-1:0]       ch_clr_in;
    logic [NUM_OUT_CH-1:0]      ch_clr_out;
    logic                       dir_sel;
    logic                       busy;
    logic                       done;

    modport slave (
        input  cmd_val, cmd_dir, cmd_ch, cmd_len, in_val, in_dat, out_rdy,
               gbf_rd_dat, gbf_rd_avail, ch_clr_in, ch_clr_out,
        output cmd_rdy, in_rdy, out_val, out_dat, gbf_wr_en, gbf_wr_addr, gbf_wr_dat,
               gbf_rd_en, gbf_rd_addr, dir_sel, busy, done
    );

    modport master (
        output cmd_val, cmd_dir, cmd_ch, cmd_len, in_val, in_dat, out_rdy,
               gbf_rd_dat, gbf_rd_avail, ch_clr_in, ch_clr_out,
        input  cmd_rdy, in_rdy, out_val, out_dat, gbf_wr_en, gbf_wr_addr, gbf_wr_dat,
               gbf_rd_en, gbf_rd_addr, dir_sel, busy, done
    );

endinterface

// File: rtl/if_chan_router_skid2.sv
// ifr_skid2: 2-entry ready/valid skid buffer on the outbound path.
//   push/push_dat : word written at the tail
//   pop           : head word consumed
//   val/dat       : buffer non-empty / head word
//   cnt           : stored entries (0..2)
module ifr_skid2 #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic          val,
    output logic [DW-1:0] dat,
    output logic [1:0]    cnt
);
    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          head_q, head_d, tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[tail_q] = push_dat;
        head_d = head_q ^ pop;
        tail_d = tail_q ^ push;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign val = cnt_q != 2'd0;
    assign dat = mem_q[head_q];
    assign cnt = cnt_q;

endmodule

// File: rtl/if_chan_router.sv
// if_chan_router: burst router between the host port FIFO stream and the GBF channels.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : command (cmd_*), inbound stream (in_*), outbound stream (out_*),
//                GBF write/read ports with per-channel address counters, counter clears,
//                and status (dir_sel, busy, done)
module if_chan_router
    import if_chan_router_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 10,
    parameter int NUM_IN_CH  = 4,
    parameter int NUM_OUT_CH = 2,
    parameter int LEN_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    if_chan_router_if.slave  bus
);
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [3:0]        ch_q, ch_d;
    logic              dir_q, dir_d, done_q, done_d;
    logic              inflight_q, cmd_rdy_q, in_rdy_q, busy_q;
    logic [NUM_IN_CH-1:0]  wr_sel, wr_en;
    logic [NUM_OUT_CH-1:0] rd_sel, rd_en;
    logic              wr_hs, rd_go, pop, skid_val, ch_ok;
    logic [1:0]        skid_cnt;
    logic [DW-1:0]     skid_dat, rd_word;

    assign wr_sel  = NUM_IN_CH'(1) << ch_q;
    assign rd_sel  = NUM_OUT_CH'(1) << ch_q;
    assign wr_hs   = bus.in_val && in_rdy_q;
    assign wr_en   = wr_hs ? wr_sel : '0;
    assign pop     = skid_val && bus.out_rdy;
    // A word popped this cycle frees its slot by the time a read issued now lands,
    // which is what lets the outbound path sustain one word per cycle.
    assign rd_go   = state_q == ST_OUT && |(bus.gbf_rd_avail & rd_sel)
                     && ({1'b0, inflight_q} + skid_cnt - {1'b0, pop}) < 2'd2;
    assign rd_en   = rd_go ? rd_sel : '0;
    assign rd_word = DW'(bus.gbf_rd_dat >> (ch_q * DW));
    assign ch_ok   = bus.cmd_dir == DIR_IN ? int'(bus.cmd_ch) < NUM_IN_CH
                                           : int'(bus.cmd_ch) < NUM_OUT_CH;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.cmd_val) begin
                dir_d = bus.cmd_dir;
                ch_d  = bus.cmd_ch;
                rem_d = bus.cmd_len;
                // Empty bursts and out-of-range channels complete without moving data.
                if (bus.cmd_len == '0 || !ch_ok) done_d = 1'b1;
                else state_d = bus.cmd_dir == DIR_IN ? ST_IN : ST_OUT;
            end
            ST_IN: if (wr_hs) begin
                rem_d = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_OUT: if (rd_go) begin
                rem_d = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
            end
            default: if (skid_cnt == 2'd0 && !inflight_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            ch_q       <= '0;
            dir_q      <= 1'b1;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            cmd_rdy_q  <= 1'b1;
            in_rdy_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            ch_q       <= ch_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            inflight_q <= rd_go;
            cmd_rdy_q  <= state_d == ST_IDLE;
            in_rdy_q   <= state_d == ST_IN;
            busy_q     <= state_d != ST_IDLE;
        end
    end

    ifr_skid2 #(.DW(DW)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_dat (rd_word),
        .pop      (pop),
        .val      (skid_val),
        .dat      (skid_dat),
        .cnt      (skid_cnt)
    );

    // Clear wins over increment so a clear on the last word still lands at 0.
    for (genvar i = 0; i < NUM_IN_CH; i++) begin : g_wr
        logic [AW-1:0] addr_q, addr_d;
        always_comb addr_d = bus.ch_clr_in[i] ? '0 : wr_en[i] ? addr_q + AW'(1) : addr_q;
        always_ff @(posedge clk) addr_q <= !rst_n ? '0 : addr_d;
        assign bus.gbf_wr_addr[i*AW +: AW] = addr_q;
    end

    for (genvar i = 0; i < NUM_OUT_CH; i++) begin : g_rd
        logic [AW-1:0] addr_q, addr_d;
        always_comb addr_d = bus.ch_clr_out[i] ? '0 : rd_en[i] ? addr_q + AW'(1) : addr_q;
        always_ff @(posedge clk) addr_q <= !rst_n ? '0 : addr_d;
        assign bus.gbf_rd_addr[i*AW +: AW] = addr_q;
    end

    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.in_rdy     = in_rdy_q;
    assign bus.out_val    = skid_val;
    assign bus.out_dat    = skid_dat;
    assign bus.gbf_wr_en  = wr_en;
    assign bus.gbf_wr_dat = wr_hs ? bus.in_dat : '0;
    assign bus.gbf_rd_en  = rd_en;
    assign bus.dir_sel    = dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_if_chan_router.sv
// tb_if_chan_router: directed self-checking bench for if_chan_router.
module tb_if_chan_router;
    import if_chan_router_pkg::*;

    localparam int DW = 16, AW = 4, NI = 4, NO = 2, LW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_chan_router_if #(.DW(DW), .AW(AW), .NUM_IN_CH(NI), .NUM_OUT_CH(NO), .LEN_W(LW)) bus ();

    if_chan_router #(.DW(DW), .AW(AW), .NUM_IN_CH(NI), .NUM_OUT_CH(NO), .LEN_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int idx;
    bit got_done;
    int t4_addr [6] = '{0, 1, 2, 0, 1, 2};

    // GBF memory model: channel 0 holds B0+addr, channel 1 holds A0+addr, one-cycle read latency.
    logic [DW-1:0] rd0_q, rd1_q;
    always @(posedge clk) begin
        if (bus.gbf_rd_en[0]) rd0_q <= 16'hB0 + 16'(bus.gbf_rd_addr[AW-1:0]);
        if (bus.gbf_rd_en[1]) rd1_q <= 16'hA0 + 16'(bus.gbf_rd_addr[2*AW-1:AW]);
    end
    assign bus.gbf_rd_dat = {rd1_q, rd0_q};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cmd_val = 0; bus.cmd_dir = 0; bus.cmd_ch = 0; bus.cmd_len = 0;
        bus.in_val = 0; bus.in_dat = 0; bus.out_rdy = 0;
        bus.gbf_rd_avail = 2'b11; bus.ch_clr_in = 0; bus.ch_clr_out = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("rst_in_rdy", 32'(bus.in_rdy), 0);
        chk("rst_out_val", 32'(bus.out_val), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dir_sel", 32'(bus.dir_sel), 1);
        chk("rst_wr_addr", 32'(bus.gbf_wr_addr), 0);
        chk("rst_rd_addr", 32'(bus.gbf_rd_addr), 0);

        // T1: inbound ch2 len5
        @(negedge clk);
        rst_n = 1;
        bus.cmd_val = 1; bus.cmd_dir = DIR_IN; bus.cmd_ch = CH_IN_WEI; bus.cmd_len = 5;
        @(negedge clk);
        bus.cmd_val = 0;
        #1;
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_cmd_rdy", 32'(bus.cmd_rdy), 0);
        chk("t1_in_rdy", 32'(bus.in_rdy), 1);
        for (int k = 0; k < 5; k++) begin
            bus.in_val = 1; bus.in_dat = 16'(256 + k);
            #1;
            chk("t1_wr_en", 32'(bus.gbf_wr_en), 4);
            chk("t1_wr_addr", 32'(bus.gbf_wr_addr[2*AW +: AW]), k);
            chk("t1_wr_dat", 32'(bus.gbf_wr_dat), 256 + k);
            chk("t1_no_done", 32'(bus.done), 0);
            @(negedge clk);
        end
        bus.in_val = 0;
        #1;
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_wr_en_off", 32'(bus.gbf_wr_en), 0);
        chk("t1_cmd_rdy_back", 32'(bus.cmd_rdy), 1);
        chk("t1_final_addr", 32'(bus.gbf_wr_addr[2*AW +: AW]), 5);
        @(negedge clk);
        #1;
        chk("t1_done_pulse", 32'(bus.done), 0);

        // T2: outbound ch1 len8 with out_rdy toggling
        @(negedge clk);
        bus.cmd_val = 1; bus.cmd_dir = DIR_OUT; bus.cmd_ch = CH_OUT_OFM; bus.cmd_len = 8;
        @(negedge clk);
        bus.cmd_val = 0;
        idx = 0; got_done = 0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            bus.out_rdy = c[0];
            #1;
            if (bus.out_val && bus.out_rdy) begin
                chk("t2_dat", 32'(bus.out_dat), 'hA0 + idx);
                idx++;
            end
            if (bus.done) begin
                got_done = 1;
                chk("t2_done_after_last", idx, 8);
            end
            @(negedge clk);
        end
        bus.out_rdy = 0;
        #1;
        chk("t2_done_seen", 32'(got_done), 1);
        chk("t2_rd_addr", 32'(bus.gbf_rd_addr[AW +: AW]), 8);
        chk("t2_dir_sel", 32'(bus.dir_sel), 0);
        chk("t2_out_val_empty", 32'(bus.out_val), 0);

        // T3: inbound ch0 len20 wraps a 4-bit address
        @(negedge clk);
        bus.cmd_val = 1; bus.cmd_dir = DIR_IN; bus.cmd_ch = CH_IN_CFG; bus.cmd_len = 20;
        @(negedge clk);
        bus.cmd_val = 0;
        for (int k = 0; k < 20; k++) begin
            bus.in_val = 1; bus.in_dat = 16'(k);
            #1;
            chk("t3_wr_en", 32'(bus.gbf_wr_en), 1);
            chk("t3_wr_addr", 32'(bus.gbf_wr_addr[AW-1:0]), k % 16);
            @(negedge clk);
        end
        bus.in_val = 0;
        #1;
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_final_addr", 32'(bus.gbf_wr_addr[AW-1:0]), 4);

        // T4: clear idle ch0, then clear mid-burst; clear of idle ch2 during the burst
        @(negedge clk);
        bus.ch_clr_in = 4'b0001;
        @(negedge clk);
        bus.ch_clr_in = 0;
        #1;
        chk("t4_idle_clear", 32'(bus.gbf_wr_addr[AW-1:0]), 0);
        @(negedge clk);
        bus.cmd_val = 1; bus.cmd_dir = DIR_IN; bus.cmd_ch = CH_IN_CFG; bus.cmd_len = 6;
        @(negedge clk);
        bus.cmd_val = 0;
        for (int k = 0; k < 6; k++) begin
            bus.in_val = 1; bus.in_dat = 16'(k);
            bus.ch_clr_in = k == 0 ? 4'b0100 : k == 2 ? 4'b0001 : 4'b0000;
            #1;
            chk("t4_wr_en", 32'(bus.gbf_wr_en), 1);
            chk("t4_wr_addr", 32'(bus.gbf_wr_addr[AW-1:0]), t4_addr[k]);
            @(negedge clk);
        end
        bus.in_val = 0; bus.ch_clr_in = 0;
        #1;
        chk("t4_done", 32'(bus.done), 1);
        chk("t4_final_addr", 32'(bus.gbf_wr_addr[AW-1:0]), 3);
        chk("t4_other_cleared", 32'(bus.gbf_wr_addr[2*AW +: AW]), 0);

        // T5: zero length and out-of-range channels
        @(negedge clk);
        bus.cmd_val = 1; bus.cmd_dir = DIR_IN; bus.cmd_ch = CH_IN_CFG; bus.cmd_len = 0;
        @(negedge clk);
        bus.cmd_val = 0;
        #1;
        chk("t5a_done", 32'(bus.done), 1);
        chk("t5a_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("t5a_busy", 32'(bus.busy), 0);
        chk("t5a_wr_en", 32'(bus.gbf_wr_en), 0);
        @(negedge clk);
        bus.cmd_val = 1; bus.cmd_dir = DIR_OUT; bus.cmd_ch = 4'd7; bus.cmd_len = 3;
        @(negedge clk);
        bus.cmd_val = 0;
        #1;
        chk("t5b_done", 32'(bus.done), 1);
        chk("t5b_rd_en", 32'(bus.gbf_rd_en), 0);
        chk("t5b_dir_sel", 32'(bus.dir_sel), 0);
        chk("t5b_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("t5b_busy", 32'(bus.busy), 0);
        @(negedge clk);
        bus.cmd_val = 1; bus.cmd_dir = DIR_IN; bus.cmd_ch = 4'd4; bus.cmd_len = 3;
        @(negedge clk);
        bus.cmd_val = 0;
        #1;
        chk("t5c_done", 32'(bus.done), 1);
        chk("t5c_wr_en", 32'(bus.gbf_wr_en), 0);
        chk("t5c_dir_sel", 32'(bus.dir_sel), 1);
        chk("t5c_in_rdy", 32'(bus.in_rdy), 0);
        @(negedge clk);
        #1;
        chk("t5c_done_pulse", 32'(bus.done), 0);

        // T6: reset during outbound burst with the skid full
        @(negedge clk);
        bus.cmd_val = 1; bus.cmd_dir = DIR_OUT; bus.cmd_ch = CH_OUT_FLGOFM; bus.cmd_len = 6;
        bus.out_rdy = 0;
        @(negedge clk);
        bus.cmd_val = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("t6_out_val", 32'(bus.out_val), 1);
        chk("t6_out_dat", 32'(bus.out_dat), 'hB0);
        chk("t6_rd_addr", 32'(bus.gbf_rd_addr[AW-1:0]), 2);
        chk("t6_busy", 32'(bus.busy), 1);
        rst_n = 0;
        @(negedge clk);
        #1;
        chk("t6_rst_out_val", 32'(bus.out_val), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_dir_sel", 32'(bus.dir_sel), 1);
        chk("t6_rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("t6_rst_rd_addr", 32'(bus.gbf_rd_addr), 0);
        chk("t6_rst_wr_addr", 32'(bus.gbf_wr_addr), 0);
        chk("t6_rst_rd_en", 32'(bus.gbf_rd_en), 0);
        rst_n = 1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
